// File: rtl/word_unpack16.sv
// word_unpack16
//   Splits each accepted 16-bit word into two bytes on an 8-bit valid/ready
//   stream. It can sustain one byte per clock because a new word may be
//   accepted on the same edge that the second byte of the current word leaves.
//
// Handshake: on both sides a transfer happens only on a posedge clk where
//   valid && ready are both 1. Valid never depends on ready. in_ready does
//   depend combinationally on out_ready; that is what allows refill in B1.
//
// Parameters
//   LSB_FIRST  1: in_data[7:0] is emitted first; 0: in_data[15:8] first
//   CNT_W      width of byte_cnt
//
// Ports
//   clk        clock, all state changes on posedge
//   res        synchronous active-low reset
//   in_data    input word
//   in_valid   in_data valid
//   in_ready   word accepted this cycle when in_valid is 1
//   out_data   output byte (8'h00 when idle)
//   out_valid  out_data valid
//   out_ready  downstream accepts the byte this cycle
//   out_last   1 while the second byte of a word is presented
//   byte_cnt   bytes handed off since reset, wraps silently
module word_unpack16 #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_B0    = 2'd1,
        ST_B1    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

    logic               in_xfer;
    logic               out_xfer;
    logic [7:0]         first_byte;
    logic [7:0]         second_byte;

    assign first_byte  = LSB_FIRST ? hold_q[7:0]  : hold_q[15:8];
    assign second_byte = LSB_FIRST ? hold_q[15:8] : hold_q[7:0];

    // Outputs decoded from state.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_last  = (state_q == ST_B1);
        out_data  = 8'h00;
        case (state_q)
            ST_B0:   out_data = first_byte;
            ST_B1:   out_data = second_byte;
            default: out_data = 8'h00;
        endcase
    end

    // res is folded in so that no word looks accepted during reset.
    assign in_ready = res && ((state_q == ST_EMPTY) ||
                              ((state_q == ST_B1) && out_ready));
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign byte_cnt = byte_cnt_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        byte_cnt_d = byte_cnt_q;

        if (out_xfer) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    hold_d  = in_data;
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (out_xfer) begin
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                // in_xfer implies out_xfer here, since in_ready needs out_ready.
                if (in_xfer) begin
                    hold_d  = in_data;
                    state_d = ST_B0;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= ST_EMPTY;
            hold_q     <= 16'h0000;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: tb/tb_word_unpack16.sv
module tb_word_unpack16;

    logic clk;
    logic res;

    // Instance a: LSB_FIRST=1, CNT_W=8
    logic [15:0] in_data_a;
    logic        in_valid_a, in_ready_a;
    logic [7:0]  out_data_a;
    logic        out_valid_a, out_ready_a, out_last_a;
    logic [7:0]  byte_cnt_a;

    // Instance m: LSB_FIRST=0
    logic [15:0] in_data_m;
    logic        in_valid_m, in_ready_m;
    logic [7:0]  out_data_m;
    logic        out_valid_m, out_ready_m, out_last_m;
    logic [7:0]  byte_cnt_m;

    // Instance c: CNT_W=2
    logic [15:0] in_data_c;
    logic        in_valid_c, in_ready_c;
    logic [7:0]  out_data_c;
    logic        out_valid_c, out_ready_c, out_last_c;
    logic [1:0]  byte_cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    word_unpack16 #(.LSB_FIRST(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .res(res),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .byte_cnt(byte_cnt_a)
    );

    word_unpack16 #(.LSB_FIRST(1'b0), .CNT_W(8)) dut_m (
        .clk(clk), .res(res),
        .in_data(in_data_m), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready_m),
        .out_last(out_last_m), .byte_cnt(byte_cnt_m)
    );

    word_unpack16 #(.LSB_FIRST(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .res(res),
        .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_last(out_last_c), .byte_cnt(byte_cnt_c)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // Move to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        res = 1'b0;
        in_data_a = 16'hFFFF; in_valid_a = 1'b1; out_ready_a = 1'b1;
        in_data_m = 16'h0000; in_valid_m = 1'b0; out_ready_m = 1'b0;
        in_data_c = 16'h0000; in_valid_c = 1'b0; out_ready_c = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({in_ready_a, out_valid_a, out_last_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/valid/last=%b required 000",
                     {in_ready_a, out_valid_a, out_last_a});
        end
        n_tests++;
        if (out_data_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 00", out_data_a);
        end
        n_tests++;
        if ({byte_cnt_a, byte_cnt_m, byte_cnt_c} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h/%h required 0/0/0",
                     byte_cnt_a, byte_cnt_m, byte_cnt_c);
        end
        in_valid_a = 1'b0;
        res = 1'b1;
        #1;
        n_tests++;
        if (in_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b required 1", in_ready_a);
        end
    endtask

    task automatic test_single;
        in_data_a = 16'hA55A; in_valid_a = 1'b1; out_ready_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        n_tests++;
        if ({out_valid_a, out_last_a, out_data_a} !== {1'b1, 1'b0, 8'h5A}) begin
            n_fail++;
            $display("FAIL single_b0: got v/l/d=%b/%b/%h required 1/0/5a",
                     out_valid_a, out_last_a, out_data_a);
        end
        tick();
        n_tests++;
        if ({out_valid_a, out_last_a, out_data_a} !== {1'b1, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_b1: got v/l/d=%b/%b/%h required 1/1/a5",
                     out_valid_a, out_last_a, out_data_a);
        end
        tick();
        n_tests++;
        if ({out_valid_a, out_data_a, byte_cnt_a} !== {1'b0, 8'h00, 8'd2}) begin
            n_fail++;
            $display("FAIL single_end: got v/d/cnt=%b/%h/%0d required 0/00/2",
                     out_valid_a, out_data_a, byte_cnt_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [0:2];
        logic [7:0]  exp_b [0:5];
        int          w;
        logic        acc;
        words[0] = 16'h0201; words[1] = 16'h0403; words[2] = 16'h0605;
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        exp_b[3] = 8'h04; exp_b[4] = 8'h05; exp_b[5] = 8'h06;
        w = 0;
        in_data_a = words[0]; in_valid_a = 1'b1; out_ready_a = 1'b1;
        tick();
        w = 1;
        in_data_a = words[1];
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++;
            if ({out_valid_a, out_last_a, out_data_a} !== {1'b1, (k % 2 == 1), exp_b[k]}) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got v/l/d=%b/%b/%h required 1/%0d/%h",
                         k, out_valid_a, out_last_a, out_data_a, k % 2, exp_b[k]);
            end
            n_tests++;
            if (in_ready_a !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b required %0d", k, in_ready_a, k % 2);
            end
            acc = in_valid_a && in_ready_a;
            tick();
            if (acc) w++;
            if (w < 3) begin
                in_data_a = words[w];
                in_valid_a = 1'b1;
            end else begin
                in_valid_a = 1'b0;
            end
        end
        n_tests++;
        if ({out_valid_a, byte_cnt_a} !== {1'b0, 8'd8}) begin
            n_fail++;
            $display("FAIL b2b_end: got v/cnt=%b/%0d required 0/8", out_valid_a, byte_cnt_a);
        end
    endtask

    task automatic test_backpressure;
        in_data_a = 16'hBEEF; in_valid_a = 1'b1; out_ready_a = 1'b0;
        tick();
        // A different word is offered but must not be taken while busy.
        in_data_a = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({out_valid_a, out_last_a, out_data_a, in_ready_a} !== {1'b1, 1'b0, 8'hEF, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_b0_%0d: got v/l/d/rdy=%b/%b/%h/%b required 1/0/ef/0",
                         k, out_valid_a, out_last_a, out_data_a, in_ready_a);
            end
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({out_valid_a, out_last_a, out_data_a, in_ready_a} !== {1'b1, 1'b1, 8'hBE, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_b1_%0d: got v/l/d/rdy=%b/%b/%h/%b required 1/1/be/0",
                         k, out_valid_a, out_last_a, out_data_a, in_ready_a);
            end
            tick();
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        n_tests++;
        if ({out_valid_a, byte_cnt_a} !== {1'b0, 8'd10}) begin
            n_fail++;
            $display("FAIL bp_end: got v/cnt=%b/%0d required 0/10", out_valid_a, byte_cnt_a);
        end
    endtask

    task automatic test_msb_first;
        in_data_m = 16'h1234; in_valid_m = 1'b1; out_ready_m = 1'b1;
        tick();
        in_valid_m = 1'b0;
        n_tests++;
        if ({out_valid_m, out_last_m, out_data_m} !== {1'b1, 1'b0, 8'h12}) begin
            n_fail++;
            $display("FAIL msb_b0: got v/l/d=%b/%b/%h required 1/0/12",
                     out_valid_m, out_last_m, out_data_m);
        end
        tick();
        n_tests++;
        if ({out_valid_m, out_last_m, out_data_m} !== {1'b1, 1'b1, 8'h34}) begin
            n_fail++;
            $display("FAIL msb_b1: got v/l/d=%b/%b/%h required 1/1/34",
                     out_valid_m, out_last_m, out_data_m);
        end
        tick();
        n_tests++;
        if ({out_valid_m, byte_cnt_m} !== {1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL msb_end: got v/cnt=%b/%0d required 0/2", out_valid_m, byte_cnt_m);
        end
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] exp_cnt [0:4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        in_data_c = 16'h2211; in_valid_c = 1'b1; out_ready_c = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (byte_cnt_c !== exp_cnt[k]) begin
                n_fail++;
                $display("FAIL cnt_wrap%0d: got %0d required %0d", k, byte_cnt_c, exp_cnt[k]);
            end
        end
        n_tests++;
        if ({out_last_c, out_data_c} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL cnt_wrap_data: got l/d=%b/%h required 1/22", out_last_c, out_data_c);
        end
        in_valid_c = 1'b0;
        tick();
        n_tests++;
        if ({out_valid_c, byte_cnt_c} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL cnt_wrap_end: got v/cnt=%b/%0d required 0/2", out_valid_c, byte_cnt_c);
        end
    endtask

    task automatic test_reset_mid_word;
        in_data_a = 16'hCAFE; in_valid_a = 1'b1; out_ready_a = 1'b1;
        tick();
        in_data_a = 16'hD00D;
        tick();
        n_tests++;
        if ({out_last_a, out_data_a} !== {1'b1, 8'hCA}) begin
            n_fail++;
            $display("FAIL mid_b1: got l/d=%b/%h required 1/ca", out_last_a, out_data_a);
        end
        res = 1'b0;
        #1;
        n_tests++;
        if (in_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_in_reset: got %b required 0", in_ready_a);
        end
        tick();
        res = 1'b1;
        in_valid_a = 1'b0;
        #1;
        n_tests++;
        if ({out_valid_a, out_last_a, out_data_a, byte_cnt_a} !== {1'b0, 1'b0, 8'h00, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_after_reset: got v/l/d/cnt=%b/%b/%h/%0d required 0/0/00/0",
                     out_valid_a, out_last_a, out_data_a, byte_cnt_a);
        end
        tick();
        n_tests++;
        if (out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_reemit: got valid=%b data=%h required valid 0",
                     out_valid_a, out_data_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_cnt_wrap();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
